// File: rtl/mem_sample_logger.sv
// mem_sample_logger: port-A write master for the dual-bank sample memory.
// Circular pre-trigger capture of (x,y) pairs; freezes after POST_SAMPLES.
module mem_sample_logger #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int POST_SAMPLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_x,
  input  logic [DATA_WIDTH-1:0] in_y,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [ADDR_WIDTH-1:0] oldest_addr,
  output logic [ADDR_WIDTH-1:0] fill,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    SECOND,
    DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FILL_MAX =
    {1'b1, {(ADDR_WIDTH-1){1'b0}}};
  localparam logic [ADDR_WIDTH:0] POST_N =
    (ADDR_WIDTH+1)'(POST_SAMPLES);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr_p2;
  logic [ADDR_WIDTH-1:0] post_cnt;
  logic [ADDR_WIDTH:0]   post_inc;
  logic [DATA_WIDTH-1:0] y_hold;
  logic                  trig_seen;
  logic                  cur_post;
  logic                  wrapped;
  logic                  accept;
  logic                  trig_new;
  logic                  last_post;

  assign wr_ptr_p2 = wr_ptr + ADDR_WIDTH'(2);
  assign post_inc  = {1'b0, post_cnt} + (ADDR_WIDTH+1)'(1);
  assign last_post = cur_post && (post_inc == POST_N);
  assign accept    = in_valid && in_ready;
  assign trig_new  = trigger && !trig_seen;

  assign oldest_addr = wrapped ? wr_ptr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (arm) state_nxt = CAPT;
      CAPT:       if (accept) state_nxt = SECOND;
      SECOND:     state_nxt = last_post ? DONE : CAPT;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state)
      CAPT:    in_ready = 1'b1;
      DONE:    done     = 1'b1;
      default: ;
    endcase
  end

  // A sample is post-trigger if the trigger was seen at or before its accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_a    <= '0;
      data_a    <= '0;
      we_a      <= 1'b0;
      trig_addr <= '0;
      fill      <= '0;
      wr_ptr    <= '0;
      post_cnt  <= '0;
      y_hold    <= '0;
      trig_seen <= 1'b0;
      cur_post  <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      we_a <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (arm) begin
            wr_ptr    <= '0;
            fill      <= '0;
            post_cnt  <= '0;
            trig_seen <= 1'b0;
            wrapped   <= 1'b0;
          end
        end
        CAPT: begin
          if (accept) begin
            addr_a   <= wr_ptr;
            data_a   <= in_x;
            we_a     <= 1'b1;
            y_hold   <= in_y;
            cur_post <= trig_seen | trigger;
          end
          if (trig_new) begin
            trig_seen <= 1'b1;
            trig_addr <= wr_ptr;
          end
        end
        SECOND: begin
          addr_a <= wr_ptr + ADDR_WIDTH'(1);
          data_a <= y_hold;
          we_a   <= 1'b1;
          wr_ptr <= wr_ptr_p2;
          if (fill != FILL_MAX) begin
            fill <= fill + ADDR_WIDTH'(1);
          end
          if (wr_ptr_p2 == '0) begin
            wrapped <= 1'b1;
          end
          if (cur_post) begin
            post_cnt <= post_inc[ADDR_WIDTH-1:0];
          end
          if (trig_new) begin
            trig_seen <= 1'b1;
            trig_addr <= wr_ptr_p2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sample_logger.sv
// tb_mem_sample_logger: vector table, directed corner cases and a
// sample-indexed reference model under random stimulus.
module tb_mem_sample_logger;

  localparam int AW   = 10;
  localparam int DW   = 16;
  localparam int POST = 4;
  localparam int NS   = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_x = '0;
  logic [DW-1:0] in_y = '0;
  logic          in_ready;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic          we_a;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] oldest_addr;
  logic [AW-1:0] fill;
  logic          done;

  int   n_chk = 0;
  int   n_pass = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  mem_sample_logger #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .POST_SAMPLES(POST)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .trigger    (trigger),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_ready   (in_ready),
    .addr_a     (addr_a),
    .data_a     (data_a),
    .we_a       (we_a),
    .trig_addr  (trig_addr),
    .oldest_addr(oldest_addr),
    .fill       (fill),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic logic [AW-1:0] sa(input int k);
    return AW'(2 * k);
  endfunction

  // Reference model: counts completed samples; sample k lives at 2k, 2k+1.
  logic          m_cap, m_busy, m_tseen, m_done, e_we;
  int            m_n, m_tidx;
  logic [DW-1:0] m_y, e_data;
  logic [AW-1:0] e_addr, m_taddr;

  always @(posedge clk) begin
    if (reset) begin
      m_cap = 0; m_busy = 0; m_tseen = 0; m_done = 0;
      m_n = 0; m_tidx = 0; m_taddr = '0; e_we = 0;
      e_addr = '0; e_data = '0; m_y = '0;
    end else begin
      e_we = 0;
      if (!m_cap) begin
        if (arm) begin
          m_cap = 1; m_n = 0; m_tseen = 0; m_done = 0;
        end
      end else if (!m_busy) begin
        if (trigger && !m_tseen) begin
          m_tseen = 1; m_tidx = m_n; m_taddr = sa(m_tidx);
        end
        if (in_valid) begin
          m_busy = 1; m_y = in_y;
          e_we = 1; e_addr = sa(m_n); e_data = in_x;
        end
      end else begin
        m_busy = 0;
        e_we = 1; e_addr = sa(m_n) + AW'(1); e_data = m_y;
        m_n++;
        if (trigger && !m_tseen) begin
          m_tseen = 1; m_tidx = m_n; m_taddr = sa(m_tidx);
        end
        if (m_tseen && m_n == m_tidx + POST) begin
          m_cap = 0; m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_ready", 32'(in_ready), 32'(m_cap && !m_busy));
      chk("m_we", 32'(we_a), 32'(e_we));
      if (e_we) begin
        chk("m_addr", 32'(addr_a), 32'(e_addr));
        chk("m_data", 32'(data_a), 32'(e_data));
      end
      chk("m_fill", 32'(fill), 32'(m_n >= NS ? NS : m_n));
      chk("m_oldest", 32'(oldest_addr), 32'(m_n > NS ? sa(m_n) : '0));
      chk("m_trig", 32'(trig_addr), 32'(m_taddr));
      chk("m_done", 32'(done), 32'(m_done));
    end
  end

  typedef struct {
    logic          arm;
    logic          vld;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic          rdy;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] fill;
  } vec_t;

  vec_t tbl[7];

  task automatic do_reset();
    reset = 1; arm = 0; in_valid = 0; trigger = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic pulse_arm();
    arm = 1;
    @(negedge clk);
    arm = 0;
  endtask

  // tm: 0 none, 1 trigger with accept, 2 trigger during y write
  task automatic put(input logic [DW-1:0] x, input logic [DW-1:0] y,
                     input int tm);
    in_valid = 1; in_x = x; in_y = y; trigger = (tm == 1);
    @(negedge clk);
    in_valid = 0; trigger = (tm == 2);
    @(negedge clk);
    trigger = 0;
  endtask

  initial begin
    tbl[0] = '{0, 1, 16'h5555, 16'h6666, 0, 0, 10'd0, 16'h0000, 10'd0};
    tbl[1] = '{1, 0, 16'h0000, 16'h0000, 1, 0, 10'd0, 16'h0000, 10'd0};
    tbl[2] = '{0, 1, 16'h0011, 16'h0022, 0, 1, 10'd0, 16'h0011, 10'd0};
    tbl[3] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 10'd1, 16'h0022, 10'd1};
    tbl[4] = '{0, 1, 16'h0033, 16'h0044, 0, 1, 10'd2, 16'h0033, 10'd1};
    tbl[5] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 10'd3, 16'h0044, 10'd2};
    tbl[6] = '{0, 0, 16'h0000, 16'h0000, 1, 0, 10'd0, 16'h0000, 10'd2};

    @(negedge clk);
    do_reset();
    chk_on = 1;
    chk("rst_addr", 32'(addr_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_we", 32'(we_a), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_trig", 32'(trig_addr), 0);
    chk("rst_oldest", 32'(oldest_addr), 0);
    chk("rst_done", 32'(done), 0);

    for (int i = 0; i < 7; i++) begin
      arm = tbl[i].arm; in_valid = tbl[i].vld;
      in_x = tbl[i].x; in_y = tbl[i].y;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_we", i), 32'(we_a), 32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(addr_a), 32'(tbl[i].addr));
        chk($sformatf("v%0d_data", i), 32'(data_a), 32'(tbl[i].data));
      end
      chk($sformatf("v%0d_fill", i), 32'(fill), 32'(tbl[i].fill));
    end
    arm = 0; in_valid = 0;

    // Wrap: 513 samples, no trigger
    do_reset();
    pulse_arm();
    for (int k = 0; k <= NS; k++) put(DW'(k), DW'(k) ^ 16'hffff, 0);
    chk("wrap_addr", 32'(addr_a), 1);
    chk("wrap_data", 32'(data_a), 32'(DW'(NS) ^ 16'hffff));
    chk("wrap_fill", 32'(fill), NS);
    chk("wrap_oldest", 32'(oldest_addr), 2);
    chk("wrap_done", 32'(done), 0);

    // Trigger with accept of sample 10
    do_reset();
    pulse_arm();
    for (int k = 0; k < 10; k++) put(DW'(k), DW'(k + 100), 0);
    put(16'h0a0a, 16'h0b0b, 1);
    chk("t4_trig", 32'(trig_addr), 20);
    put(16'h1111, 16'h2222, 0);
    put(16'h3333, 16'h4444, 0);
    chk("t4_notdone", 32'(done), 0);
    put(16'h5555, 16'h6666, 0);
    chk("t4_done", 32'(done), 1);
    chk("t4_last", 32'(addr_a), 27);
    in_valid = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_rdy", 32'(in_ready), 0);
      chk("t4_we", 32'(we_a), 0);
    end
    in_valid = 0;

    // Trigger during y write of sample 10
    do_reset();
    pulse_arm();
    for (int k = 0; k < 10; k++) put(DW'(k), DW'(k + 200), 0);
    put(16'h0a0a, 16'h0b0b, 2);
    chk("t5_trig", 32'(trig_addr), 22);
    put(16'h0101, 16'h0202, 0);
    put(16'h0303, 16'h0404, 1);
    chk("t5_trig2", 32'(trig_addr), 22);
    put(16'h0505, 16'h0606, 0);
    chk("t5_notdone", 32'(done), 0);
    put(16'h0707, 16'h0808, 0);
    chk("t5_done", 32'(done), 1);
    chk("t5_last", 32'(addr_a), 29);
    trigger = 1;
    repeat (2) @(negedge clk);
    trigger = 0;
    chk("t5_trig3", 32'(trig_addr), 22);
    chk("t5_hold", 32'(done), 1);

    // Reset mid-SECOND, arm ignored while capturing
    do_reset();
    pulse_arm();
    put(16'h000a, 16'h000b, 0);
    pulse_arm();
    chk("t6_armign_rdy", 32'(in_ready), 1);
    chk("t6_armign_fill", 32'(fill), 1);
    in_valid = 1; in_x = 16'h000c; in_y = 16'h000d;
    @(negedge clk);
    chk("t6_x_addr", 32'(addr_a), 2);
    in_valid = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t6_rst_we", 32'(we_a), 0);
    chk("t6_rst_rdy", 32'(in_ready), 0);
    chk("t6_rst_fill", 32'(fill), 0);
    pulse_arm();
    in_valid = 1; in_x = 16'h00d0; in_y = 16'h00e0;
    @(negedge clk);
    in_valid = 0;
    chk("t6_re_we", 32'(we_a), 1);
    chk("t6_re_addr", 32'(addr_a), 0);
    chk("t6_re_data", 32'(data_a), 16'h00d0);
    @(negedge clk);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      arm      = ($urandom_range(0, 39) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_x     = DW'($urandom);
      in_y     = DW'($urandom);
      trigger  = ($urandom_range(0, 99) == 0);
      reset    = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 0; arm = 0; in_valid = 0; trigger = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
